// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and width helpers for the Stein GCD engine.
//   gcd_state_e   controller states
//   k_width()     bits needed for the common power-of-two exponent
//   cycles_width() bits needed for the cycle counter (holds up to 4*W+4)
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STRIP,
    NORM,
    RUN,
    FIN,
    ERR
  } gcd_state_e;

  // k counts shared trailing zeros; it never exceeds width-1 for nonzero operands.
  function automatic int k_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int cycles_width(input int width);
    return $clog2(4 * width + 5);
  endfunction

endpackage

// File: rtl/gcd_absdiff.sv
// gcd_absdiff: combinational magnitude compare and absolute difference.
//   a, b    : WIDTH-bit unsigned operands
//   a_gt_b  : 1 when a > b
//   diff    : |a - b|, computed with the larger operand as minuend so it
//             never wraps
module gcd_absdiff #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             a_gt_b,
  output logic [WIDTH-1:0] diff
);

  always_comb begin
    a_gt_b = (a > b);
    diff   = a_gt_b ? (a - b) : (b - a);
  end

endmodule

// File: rtl/gcd_stein.sv
// gcd_stein: binary (Stein) GCD engine with START/DONE/ERROR handshake.
//   CLK, RST_N : clock, synchronous active-low reset
//   A, B       : operands, captured only when START is accepted in IDLE
//   START      : request, ignored unless idle
//   BUSY       : high while STRIP/NORM/RUN are in progress
//   Y          : gcd(A,B), held until the next completion
//   DONE       : one-cycle pulse, Y valid
//   ERROR      : one-cycle pulse, an operand was zero, Y cleared
//   CYCLES     : STRIP+NORM+RUN cycles used by the last operation
module gcd_stein
  import gcd_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CW    = cycles_width(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             START,
  output logic             BUSY,
  output logic [WIDTH-1:0] Y,
  output logic             DONE,
  output logic             ERROR,
  output logic [CW-1:0]    CYCLES
);

  localparam int KW = k_width(WIDTH);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic             a_gt_b;
  logic [WIDTH-1:0] diff;

  gcd_absdiff #(.WIDTH(WIDTH)) u_absdiff (
    .a      (a_q),
    .b      (b_q),
    .a_gt_b (a_gt_b),
    .diff   (diff)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    cycles_d = cycles_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          a_d   = A;
          b_d   = B;
          k_d   = '0;
          cnt_d = '0;
          if (A == '0 || B == '0) begin
            // Clear results on entry so Y already reads 0 during the ERROR pulse.
            y_d      = '0;
            cycles_d = '0;
            state_d  = ERR;
          end else begin
            state_d = STRIP;
          end
        end
      end

      STRIP: begin
        cnt_d = cnt_q + CW'(1);
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = NORM;
        end
      end

      NORM: begin
        cnt_d = cnt_q + CW'(1);
        if (!a_q[0]) a_d = a_q >> 1;
        else         state_d = RUN;
      end

      // a stays odd throughout RUN; b carries the working difference.
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (b_q == '0) begin
          // Results land on the FIN entry edge so Y is valid alongside DONE.
          y_d      = a_q << k_q;
          cycles_d = cnt_q + CW'(1);
          state_d  = FIN;
        end else if (!b_q[0]) begin
          b_d = b_q >> 1;
        end else if (a_gt_b) begin
          a_d = b_q;
          b_d = diff;
        end else begin
          b_d = diff;
        end
      end

      FIN:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge, and all state uses
  // non-blocking assignment so every register updates from pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      cycles_q <= cycles_d;
    end
  end

  assign BUSY   = (state_q == STRIP) || (state_q == NORM) || (state_q == RUN);
  assign DONE   = (state_q == FIN);
  assign ERROR  = (state_q == ERR);
  assign Y      = y_q;
  assign CYCLES = cycles_q;

endmodule

// File: tb/tb_gcd_stein.sv
// tb_gcd_stein: directed and random checks of gcd_stein at WIDTH=16 and 8.
module tb_gcd_stein;
  import gcd_pkg::*;

  localparam int CW16 = cycles_width(16);
  localparam int CW8  = cycles_width(8);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [15:0]     a16, b16, y16;
  logic            start16, busy16, done16, error16;
  logic [CW16-1:0] cycles16;

  logic [7:0]      a8, b8, y8;
  logic            start8, busy8, done8, error8;
  logic [CW8-1:0]  cycles8;

  gcd_stein #(.WIDTH(16)) dut16 (
    .CLK(clk), .RST_N(rst_n), .A(a16), .B(b16), .START(start16),
    .BUSY(busy16), .Y(y16), .DONE(done16), .ERROR(error16), .CYCLES(cycles16)
  );

  gcd_stein #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST_N(rst_n), .A(a8), .B(b8), .START(start8),
    .BUSY(busy8), .Y(y8), .DONE(done8), .ERROR(error8), .CYCLES(cycles8)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [15:0] y;
    int          cycles;
    int          lat;
    int          busy_cnt;
    bit          done_seen;
    bit          err_seen;
    bit          excl_ok;
    bit          pulse_ok;
    bit          timeout;
  } res_t;

  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic drive(input bit w8, input logic [15:0] a, input logic [15:0] b,
                       input logic s);
    if (w8) begin
      a8 = a[7:0]; b8 = b[7:0]; start8 = s;
    end else begin
      a16 = a; b16 = b; start16 = s;
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge
  // one cycle after the DONE/ERROR pulse, so the next call is back-to-back.
  // poke_at >= 0 raises START (with pa/pb) for one cycle while busy.
  task automatic run_op(input bit w8, input logic [15:0] a, input logic [15:0] b,
                        input int poke_at, input logic [15:0] pa,
                        input logic [15:0] pb, output res_t r);
    logic d, e, bsy;
    r = '{default: 0};
    r.excl_ok = 1'b1;
    drive(w8, a, b, 1'b1);
    @(negedge clk);
    drive(w8, a, b, 1'b0);
    forever begin
      d   = w8 ? done8  : done16;
      e   = w8 ? error8 : error16;
      bsy = w8 ? busy8  : busy16;
      if (d && e) r.excl_ok = 1'b0;
      if (d || e) break;
      if (bsy) r.busy_cnt++;
      if (r.lat >= 200) begin
        r.timeout = 1'b1;
        break;
      end
      if (r.lat == poke_at) drive(w8, pa, pb, 1'b1);
      else                  drive(w8, pa, pb, 1'b0);
      @(negedge clk);
      r.lat++;
    end
    drive(w8, pa, pb, 1'b0);
    r.done_seen = d;
    r.err_seen  = e;
    r.y         = w8 ? {8'h00, y8} : y16;
    r.cycles    = w8 ? int'(cycles8) : int'(cycles16);
    @(negedge clk);
    r.pulse_ok = w8 ? !(done8 || error8 || busy8) : !(done16 || error16 || busy16);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'd0, 16'd0, 1'b0);
    drive(1'b1, 16'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy16, done16, error16} !== 3'b000) begin
      failed++; $display("FAIL reset_flags16: got %b expected 000", {busy16, done16, error16});
    end
    tests++;
    if (y16 !== 16'd0 || cycles16 !== '0) begin
      failed++; $display("FAIL reset_data16: got y=%0d cycles=%0d expected 0 0", y16, cycles16);
    end
    tests++;
    if ({busy8, done8, error8} !== 3'b000 || y8 !== 8'd0 || cycles8 !== '0) begin
      failed++; $display("FAIL reset_dut8: got flags=%b y=%0d cycles=%0d expected all 0",
                         {busy8, done8, error8}, y8, cycles8);
    end
  endtask

  task automatic test_basic();
    res_t r;
    run_op(1'b0, 16'd48, 16'd18, -1, 16'd48, 16'd18, r);
    tests++;
    if (!r.done_seen || r.err_seen || r.timeout) begin
      failed++; $display("FAIL basic_handshake: got done=%0d err=%0d timeout=%0d expected 1 0 0",
                         r.done_seen, r.err_seen, r.timeout);
    end
    tests++;
    if (r.y !== 16'd6) begin
      failed++; $display("FAIL basic_y: got %0d expected 6", r.y);
    end
    tests++;
    if (r.cycles != 10 || r.lat != 10) begin
      failed++; $display("FAIL basic_cycles: got cycles=%0d latency=%0d expected 10 10", r.cycles, r.lat);
    end
    tests++;
    if (r.busy_cnt != 10) begin
      failed++; $display("FAIL basic_busy: got %0d busy cycles expected 10", r.busy_cnt);
    end
    tests++;
    if (!r.pulse_ok) begin
      failed++; $display("FAIL basic_pulse: got DONE/BUSY still active one cycle later expected idle");
    end
  endtask

  task automatic test_equal_w8();
    res_t r;
    run_op(1'b1, 16'd255, 16'd255, -1, 16'd255, 16'd255, r);
    tests++;
    if (!r.done_seen || r.y !== 16'd255) begin
      failed++; $display("FAIL equal8_y: got done=%0d y=%0d expected 1 255", r.done_seen, r.y);
    end
    tests++;
    if (r.cycles != 4 || r.lat != 4) begin
      failed++; $display("FAIL equal8_cycles: got cycles=%0d latency=%0d expected 4 4", r.cycles, r.lat);
    end
  endtask

  task automatic test_zero_operand();
    res_t r;
    logic [15:0] za[2] = '{16'd0, 16'd7};
    logic [15:0] zb[2] = '{16'd5, 16'd0};
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, za[i], zb[i], -1, za[i], zb[i], r);
      tests++;
      if (!r.err_seen || r.done_seen || r.timeout) begin
        failed++; $display("FAIL zero%0d_flags: got err=%0d done=%0d timeout=%0d expected 1 0 0",
                           i, r.err_seen, r.done_seen, r.timeout);
      end
      // ERROR appears in the cycle right after the accepting edge.
      tests++;
      if (r.lat != 0 || r.busy_cnt != 0) begin
        failed++; $display("FAIL zero%0d_latency: got latency=%0d busy=%0d expected 0 0",
                           i, r.lat, r.busy_cnt);
      end
      tests++;
      if (r.y !== 16'd0 || r.cycles != 0) begin
        failed++; $display("FAIL zero%0d_data: got y=%0d cycles=%0d expected 0 0", i, r.y, r.cycles);
      end
      tests++;
      if (!r.pulse_ok) begin
        failed++; $display("FAIL zero%0d_pulse: got ERROR/BUSY active afterwards expected idle", i);
      end
      if (i == 0) begin
        // Put a nonzero result back so the second case proves Y is cleared.
        run_op(1'b0, 16'd9, 16'd6, -1, 16'd9, 16'd6, r);
      end
    end
  endtask

  task automatic test_start_while_busy();
    res_t r;
    run_op(1'b0, 16'd1, 16'd65535, 3, 16'd6, 16'd4, r);
    tests++;
    if (!r.done_seen || r.y !== 16'd1) begin
      failed++; $display("FAIL busy_ignore_y: got done=%0d y=%0d expected 1 1", r.done_seen, r.y);
    end
    tests++;
    if (r.cycles != 34 || r.cycles > 68 || r.lat != 34) begin
      failed++; $display("FAIL busy_ignore_cycles: got cycles=%0d latency=%0d expected 34 34",
                         r.cycles, r.lat);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy16 !== 1'b0 || done16 !== 1'b0) begin
      failed++; $display("FAIL busy_ignore_queued: got busy=%0d done=%0d expected 0 0", busy16, done16);
    end
  endtask

  task automatic test_reset_mid_run();
    res_t r;
    bit   stray_done;
    drive(1'b0, 16'd1024, 16'd96, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'd1024, 16'd96, 1'b0);
    // RUN spans edges 12..15 after acceptance; edge 14 is mid-RUN.
    repeat (14) @(negedge clk);
    tests++;
    if (busy16 !== 1'b1) begin
      failed++; $display("FAIL midrun_busy: got %0d expected 1", busy16);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if ({busy16, done16, error16} !== 3'b000 || y16 !== 16'd0 || cycles16 !== '0) begin
      failed++; $display("FAIL midrun_reset: got flags=%b y=%0d cycles=%0d expected all 0",
                         {busy16, done16, error16}, y16, cycles16);
    end
    stray_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done16 || busy16) stray_done = 1'b1;
    end
    tests++;
    if (stray_done) begin
      failed++; $display("FAIL midrun_discard: got activity after reset expected none");
    end
    run_op(1'b0, 16'd1024, 16'd96, -1, 16'd1024, 16'd96, r);
    tests++;
    if (!r.done_seen || r.y !== 16'd32 || r.cycles != 16) begin
      failed++; $display("FAIL midrun_rerun: got done=%0d y=%0d cycles=%0d expected 1 32 16",
                         r.done_seen, r.y, r.cycles);
    end
  endtask

  task automatic test_back_to_back();
    res_t        r;
    logic [15:0] a, b;
    int          exp_y, bound, wmax;
    bit          ok;
    for (int n = 0; n < 2000; n++) begin
      bit w8 = (n < 1200);
      wmax   = w8 ? 255 : 65535;
      bound  = w8 ? 36 : 68;
      a      = 16'($urandom_range(1, wmax));
      b      = 16'($urandom_range(1, wmax));
      exp_y  = ref_gcd(int'(a), int'(b));
      run_op(w8, a, b, -1, a, b, r);
      ok = r.done_seen && !r.err_seen && !r.timeout && r.excl_ok
           && (int'(r.y) == exp_y) && (r.cycles <= bound) && (r.lat == r.cycles);
      tests++;
      if (!ok) begin
        failed++;
        if (failed < 40)
          $display("FAIL random_w%0d: a=%0d b=%0d got y=%0d cycles=%0d lat=%0d done=%0d err=%0d excl=%0d expected y=%0d cycles<=%0d lat=cycles",
                   w8 ? 8 : 16, a, b, r.y, r.cycles, r.lat, r.done_seen, r.err_seen, r.excl_ok,
                   exp_y, bound);
      end
    end
  endtask

  initial begin
    a16 = '0; b16 = '0; start16 = 1'b0;
    a8  = '0; b8  = '0; start8  = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_basic();
    test_equal_w8();
    test_zero_operand();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
